// File: rtl/bcd_pkg.sv
// Shared types and sizing for the product BCD converter.
package bcd_pkg;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BCD_W  = 4 * DIGITS;

  // Wide enough to hold the value WIDTH itself, since the count starts there.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/product_bcd_converter.sv
// Iterative binary-to-BCD converter, one input bit per clock, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a product, in_ready high
// SHIFT | add-3 and shift, WIDTH clocks
// DONE  | result held on bcd, out_valid high until consumed
module product_bcd_converter
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] bcd
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] scratch_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_shift;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*d +: 4]),
      .dout (scratch_adj[4*d +: 4])
    );
  end

  // The top bit of the digit chain falls off; DIGITS is sized so it is always zero.
  assign scratch_nxt = {scratch_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign last_shift  = (cnt == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE:    if (in_valid)   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_sr  <= in_data;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (last_shift) bcd <= scratch_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against an arithmetic BCD model.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;

  int tests = 0;
  int fails = 0;

  product_bcd_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers v, waits for acceptance, then checks latency and result; returns at the
  // negedge where out_valid is first seen.
  task automatic convert(input logic [7:0] v);
    int n;
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'(~v);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 8);
    check("bcd", {20'd0, bcd}, {20'd0, ref_bcd(int'(v))});
  endtask

  int          cyc;
  int          acc_cyc[$];
  logic [11:0] res_q[$];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 15x15 with out_ready already high
    convert(8'd225);
    @(negedge clk);
    check("handoff_idle", {31'd0, in_ready}, 32'd1);
    check("handoff_valid", {31'd0, out_valid}, 32'd0);
    check("bcd_kept", {20'd0, bcd}, 32'h225);

    for (int v = 0; v < 256; v++) begin
      convert(8'(v));
      @(negedge clk);
      check("sweep_idle", {31'd0, in_ready}, 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      convert(8'($urandom_range(255)));
      @(negedge clk);
    end

    // Backpressure
    out_ready = 1'b0;
    convert(8'd144);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_bcd", {20'd0, bcd}, 32'h144);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_idle", {31'd0, in_ready}, 32'd1);

    // New in_valid during SHIFT must be ignored until IDLE returns
    in_valid = 1'b1;
    in_data  = 8'd50;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'd7;
    begin
      int n = 1;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("ign_latency", n, 9);
    end
    check("ign_bcd", {20'd0, bcd}, 32'h050);
    convert(8'd7);
    @(negedge clk);

    // Asynchronous reset in the 4th SHIFT cycle
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_bcd", {20'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);
    end
    convert(8'd64);
    @(negedge clk);

    // Back-to-back with in_valid held
    in_valid = 1'b1;
    in_data  = 8'd12;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) res_q.push_back(bcd);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc_cyc.size() == 1) in_data = 8'd200;
      if (acc_cyc.size() == 2) in_valid = 1'b0;
    end
    check("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 10);
    check("b2b_results", res_q.size(), 2);
    if (res_q.size() == 2) begin
      check("b2b_first", {20'd0, res_q[0]}, 32'h012);
      check("b2b_second", {20'd0, res_q[1]}, 32'h200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
